// File: rtl/atan_rr_arbiter.sv
// Round-robin arbiter that time-shares one combinational atan unit between NUM_REQ requesters.
// Two registered stages: A holds the granted operands, B holds the tagged result.
module atan_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_x,
  input  logic [16*NUM_REQ-1:0] req_y,
  output logic [15:0]           atan_x,
  output logic [15:0]           atan_y,
  input  logic [7:0]            atan_angle,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [7:0]            res_angle,
  output logic [ID_W-1:0]       res_id
);

  logic            a_valid_q, a_valid_d;
  logic [15:0]     a_x_q, a_x_d;
  logic [15:0]     a_y_q, a_y_d;
  logic [ID_W-1:0] a_id_q, a_id_d;
  logic            b_valid_q, b_valid_d;
  logic [7:0]      b_angle_q, b_angle_d;
  logic [ID_W-1:0] b_id_q, b_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            b_free;
  logic            a_free;
  logic            any_req;
  logic            accept;
  logic            found;
  logic [ID_W-1:0] grant;

  assign b_free  = !b_valid_q || res_ready;
  assign a_free  = !a_valid_q || b_free;
  assign any_req = |req_valid;
  assign accept  = any_req && a_free;

  // Rotating priority: first valid at or above ptr, otherwise wrap to the lowest valid index.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= 32'(ptr_q))) begin
        grant = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        grant = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  // Gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && accept && (grant == ID_W'(i));
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_x_d     = a_x_q;
    a_y_d     = a_y_q;
    a_id_d    = a_id_q;
    ptr_d     = ptr_q;
    if (a_free) begin
      a_valid_d = accept;
      if (accept) begin
        a_x_d  = req_x[16*grant +: 16];
        a_y_d  = req_y[16*grant +: 16];
        a_id_d = grant;
        ptr_d  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_angle_d = b_angle_q;
    b_id_d    = b_id_q;
    if (b_free) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_angle_d = atan_angle;
        b_id_d    = a_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_x_q     <= '0;
      a_y_q     <= '0;
      a_id_q    <= '0;
      b_valid_q <= 1'b0;
      b_angle_q <= '0;
      b_id_q    <= '0;
      ptr_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_x_q     <= a_x_d;
      a_y_q     <= a_y_d;
      a_id_q    <= a_id_d;
      b_valid_q <= b_valid_d;
      b_angle_q <= b_angle_d;
      b_id_q    <= b_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign atan_x    = a_x_q;
  assign atan_y    = a_y_q;
  assign res_valid = b_valid_q;
  assign res_angle = b_angle_q;
  assign res_id    = b_id_q;

endmodule

// File: tb/tb_atan_rr_arbiter.sv
// Bench for atan_rr_arbiter: scenario tasks plus a scoreboard that pairs accepts with results.
module tb_atan_rr_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [16*N-1:0]  req_x;
  logic [16*N-1:0]  req_y;
  logic [15:0]      atan_x;
  logic [15:0]      atan_y;
  logic [7:0]       atan_angle;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_angle;
  logic [IDW-1:0]   res_id;

  logic [15:0] xs [N];
  logic [15:0] ys [N];
  logic        sb_en;
  logic        use_real;
  int          n_checks;
  int          n_pass;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     angle;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  atan_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .atan_x    (atan_x),
    .atan_y    (atan_y),
    .atan_angle(atan_angle),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_angle (res_angle),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < N; i++) begin
      req_x[16*i +: 16] = xs[i];
      req_y[16*i +: 16] = ys[i];
    end
  end

  // Reference binary angle: 256 steps per turn, rounded to nearest.
  function automatic logic [7:0] atan_ref(input logic [15:0] x, input logic [15:0] y);
    real a;
    int  q;
    a = $atan2($itor($signed(y)), $itor($signed(x))) * 128.0 / 3.141592653589793;
    q = $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
    return 8'(q);
  endfunction

  always_comb begin
    if (use_real) atan_angle = atan_ref(atan_x, atan_y);
    else          atan_angle = atan_x[7:0] ^ atan_y[7:0];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (sb_en) begin
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_extra: got id=%0d angle=%h, required no result", res_id, res_angle);
        end else begin
          e = sb.pop_front();
          if (res_id !== e.id || res_angle !== e.angle)
            $display("FAIL sb_result: got id=%0d angle=%h, required id=%0d angle=%h",
                     res_id, res_angle, e.id, e.angle);
          else n_pass++;
        end
      end
      n_checks++;
      if ($countones(req_ready) > 1) $display("FAIL onehot: got req_ready=%b", req_ready);
      else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back('{id: IDW'(i), angle: xs[i][7:0] ^ ys[i][7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int granted();
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) return i;
    return -1;
  endfunction

  task automatic set_default_data();
    for (int i = 0; i < N; i++) begin
      xs[i] = 16'(16'h0111 * (i + 1));
      ys[i] = 16'h0f40;
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_default_data();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0 || res_angle !== 8'h00 || res_id !== 2'd0 ||
        atan_x !== 16'h0 || atan_y !== 16'h0)
      $display("FAIL reset_state: got ready=%b rv=%b ang=%h id=%0d ax=%h ay=%h, required all 0",
               req_ready, res_valid, res_angle, res_id, atan_x, atan_y);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b, required 0001", req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    apply_reset();
    res_ready = 1'b1;
    xs[2] = 16'h0012;
    ys[2] = 16'h0034;
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100 || res_valid !== 1'b0)
      $display("FAIL single_accept: got ready=%b rv=%b, required 0100 0", req_ready, res_valid);
    else n_pass++;
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || atan_x !== 16'h0012 || atan_y !== 16'h0034)
      $display("FAIL single_stage_a: got rv=%b ax=%h ay=%h, required 0 0012 0034",
               res_valid, atan_x, atan_y);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_angle !== 8'h26 || res_id !== 2'd2)
      $display("FAIL single_result: got rv=%b ang=%h id=%0d, required 1 26 2",
               res_valid, res_angle, res_id);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL single_idle: got rv=%b, required 0", res_valid);
    else n_pass++;
    // Extreme operands must reach the atan unit untouched.
    xs[3] = 16'h8000;
    ys[3] = 16'h0000;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (atan_x !== 16'h8000 || atan_y !== 16'h0000)
      $display("FAIL passthrough: got ax=%h ay=%h, required 8000 0000", atan_x, atan_y);
    else n_pass++;
    repeat (3) tick();
    set_default_data();
  endtask

  task automatic test_round_robin();
    int g;
    apply_reset();
    res_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g = granted();
      n_checks++;
      if (g != k % 4) $display("FAIL rr_order[%0d]: got %0d, required %0d", k, g, k % 4);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== IDW'((k - 2) % 4))
          $display("FAIL rr_stream[%0d]: got rv=%b id=%0d, required 1 %0d",
                   k, res_valid, res_id, (k - 2) % 4);
        else n_pass++;
      end
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || res_valid !== 1'b0)
      $display("FAIL rr_drain: got pending=%0d rv=%b, required 0 0", sb.size(), res_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc;
    apply_reset();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (granted() >= 0) acc++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (acc != 2 || req_ready !== 4'b0000)
      $display("FAIL bp_fill: got accepts=%0d ready=%b, required 2 0000", acc, req_ready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_angle !== (xs[0][7:0] ^ ys[0][7:0]) ||
        atan_x !== xs[1])
      $display("FAIL bp_frozen: got rv=%b id=%0d ang=%h ax=%h, required 1 0 %h %h",
               res_valid, res_id, res_angle, atan_x, xs[0][7:0] ^ ys[0][7:0], xs[1]);
    else n_pass++;
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (granted() != 2) $display("FAIL bp_release_grant: got %0d, required 2", granted());
    else n_pass++;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || req_ready !== 4'b0000 || atan_x !== xs[2])
      $display("FAIL bp_one_step: got rv=%b id=%0d ready=%b ax=%h, required 1 1 0000 %h",
               res_valid, res_id, req_ready, atan_x, xs[2]);
    else n_pass++;
  endtask

  task automatic test_skip_idle();
    int exp_seq [4] = '{1, 3, 1, 3};
    apply_reset();
    res_ready = 1'b1;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (granted() != exp_seq[k])
        $display("FAIL skip_order[%0d]: got %0d, required %0d", k, granted(), exp_seq[k]);
      else n_pass++;
      tick();
    end
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (granted() != 1) $display("FAIL skip_b2b[%0d]: got %0d, required 1", k, granted());
      else n_pass++;
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (3) tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL mid_full: got rv=%b, required 1", res_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL mid_async: got rv=%b, required 0", res_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) $display("FAIL mid_quiet[%0d]: got rv=%b, required 0", k, res_valid);
      else n_pass++;
      tick();
    end
    req_valid = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL mid_regrant: got %b, required 1000", req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL mid_latency: got rv=%b, required 0", res_valid);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd3)
      $display("FAIL mid_result: got rv=%b id=%0d, required 1 3", res_valid, res_id);
    else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_real_atan();
    logic [15:0] tx  [3] = '{16'd100, -16'sd100, 16'd0};
    logic [15:0] ty  [3] = '{16'd0, 16'd0, -16'sd100};
    logic [7:0]  exp [3] = '{8'd0, 8'd128, 8'd192};
    sb_en    = 1'b0;
    use_real = 1'b1;
    apply_reset();
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      xs[0] = tx[k];
      ys[0] = ty[k];
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_angle !== exp[k])
        $display("FAIL real_atan[%0d]: got rv=%b ang=%0d, required 1 %0d",
                 k, res_valid, res_angle, exp[k]);
      else n_pass++;
      tick();
    end
    use_real = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    sb_en     = 1'b1;
    use_real  = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    set_default_data();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_idle();
    test_reset_mid();
    test_real_atan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/atan_rr_arbiter.md
Name: atan_rr_arbiter

Overview:
- Shares one combinational atan angle unit (16-bit signed x/y in, 8-bit binary angle out, 256 = full turn) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester port and on the result port.
- Registered two-stage pipeline around the shared unit; each result is tagged with the originating requester ID.
- Sits between the per-channel vector sources and the angle consumers.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- ID_W, 2, width of requester ID; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_x  in  16*NUM_REQ  signed x, requester i at bits [16i+15:16i].
- req_y  in  16*NUM_REQ  signed y, same packing.
- atan_x  out  16  x to the shared atan unit.
- atan_y  out  16  y to the shared atan unit.
- atan_angle  in  8  angle returned combinationally by the shared atan unit.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accept.
- res_angle  out  8  result angle.
- res_id  out  ID_W  requester index of the result.

Behaviour:
- Reset (async assert, sync release):
  - Stage A and B valid flags = 0, res_valid = 0.
  - res_angle, res_id, atan_x, atan_y = 0.
  - Priority pointer ptr = 0.
- Stage A registers: a_valid, a_x, a_y, a_id. atan_x/atan_y are driven directly from a_x/a_y.
- Stage B registers: res_valid, res_angle, res_id.
- Handshake rule: transfer on a port when valid & ready are both high at a rising edge.
  - Requesters must hold req_x/req_y stable while req_valid is high and not yet accepted.
  - The block never drops a request it has not accepted.
- Stall and advance:
  - b_free = !res_valid | res_ready.
  - a_free = !a_valid | b_free.
  - On an edge with a_valid & b_free: res_valid <= 1, res_angle <= atan_angle, res_id <= a_id.
  - On an edge with b_free & !a_valid: res_valid <= 0.
  - When !b_free, stage B holds its value.
- Grant selection (combinational):
  - Scan indices ptr, ptr+1, … mod NUM_REQ; grant = first i with req_valid[i].
  - req_ready[i] = (i == grant) & any(req_valid) & a_free.
  - req_ready depends on req_valid; req_valid must not depend on req_ready.
- On an accept from requester g: a_valid <= 1, a_x/a_y <= req_x/req_y slice g, a_id <= g, ptr <= (g+1) mod NUM_REQ.
- If a_free and no request is pending: a_valid <= 0 and ptr is unchanged.
- Latency and throughput:
  - Request accepted at edge t → res_valid high after edge t+1, i.e. 2 cycles from presentation with no stall.
  - Sustained throughput is 1 result/cycle while res_ready stays high.
- Backpressure:
  - With res_ready low, the pipeline holds at most 2 in-flight items.
  - After both stages fill, all req_ready bits go low.
  - Registers and atan_x/atan_y stay frozen; res_angle is stable while res_valid is high and not accepted.
- Simultaneous drain and accept (res_ready=1 with both stages full): B takes A's result and A accepts a new request on the same edge, so there is no bubble.
- Results leave in acceptance order; there is no reordering.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 accepts before its own.
- NUM_REQ=1: grant is always 0; res_id is a 1-bit 0.
- The arbiter does no arithmetic on x/y. It passes them bit-exact, including 0,0 and -32768.
- Reset mid-operation: all in-flight items are discarded. No res_valid is produced until a new request is accepted after reset release.

Test Plan:
- Bench stub for the atan unit: atan_angle = atan_x[7:0] ^ atan_y[7:0].
- Reset check: hold rst_n=0 with req_valid=4'b1111 → req_ready=0, res_valid=0, res_angle=0, res_id=0; after release, the first grant goes to requester 0.
- Single request, no stall: req 2 with x=0x0012, y=0x0034, res_ready=1 → accepted with req_ready=4'b0100, res_valid high 2 cycles later, res_angle=0x26, res_id=2, then res_valid returns to 0.
- Round-robin, full load: all four valid continuously, res_ready=1 → accept order 0,1,2,3,0,1…; res_id follows the same sequence with one result per cycle and no gaps.
- Backpressure: all valid, res_ready=0 → exactly 2 accepts, then req_ready=0 and res_angle/res_id frozen. Raising res_ready for 1 cycle gives exactly one result out and one new accept on the same edge.
- Skipping idle requesters: only req 1 and req 3 valid, ptr=0 → order 1,3,1,3. Dropping req 3 mid-stream gives back-to-back accepts for req 1.
- Reset mid-flight: both stages full, pulse rst_n low for 1 cycle → res_valid=0 immediately (async) and remains 0 until a new request is accepted and 2 cycles elapse.
- Real atan unit instance:
  - (100, 0) → 0
  - (-100, 0) → 128
  - (0, -100) → 192
